// File: rtl/rx_pkt_isolator.sv
// Ingress store-and-forward isolator between the MAC receive stream and the user path.
// Frames are released only once complete and good; dropped frames are counted by cause.
module rx_pkt_isolator #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned FIFO_DEPTH     = 2048,
    parameter int unsigned DROP_THRESHOLD = 256,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                        user_clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_WIDTH-1:0]        rx_pkt_count,
    output logic [CNT_WIDTH-1:0]        drop_pkt_count,
    output logic [CNT_WIDTH-1:0]        overflow_count,
    output logic [CNT_WIDTH-1:0]        bad_pkt_count
);

    localparam int unsigned KW = DATA_WIDTH / 8;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned WW = DATA_WIDTH + KW + 1;

    typedef enum logic [1:0] {StSync, StIdle, StStore, StDiscard} state_e;

    state_e                  state_q, state_d;
    logic                    in_valid_q, in_last_q, in_user_q, armed_q;
    logic [DATA_WIDTH-1:0]   in_data_q;
    logic [KW-1:0]           in_keep_q;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
    logic [PW-1:0]           used, free, fetch_ptr;
    logic                    full, admit, mem_we, load, handshake;
    logic                    inc_rx, inc_drop, inc_ovf, inc_bad;
    logic [WW-1:0]           mem_q [FIFO_DEPTH];
    logic [WW-1:0]           m_word_q;
    logic                    m_valid_q;
    logic [CNT_WIDTH-1:0]    rx_q, drop_q, ovf_q, bad_q;

    // armed_q marks that the input register holds a real sample rather than its reset value,
    // so SYNC does not mistake the cleared register for an inter-frame gap.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            in_valid_q <= s_axis_tvalid;
            armed_q    <= 1'b1;
        end
        in_data_q <= s_axis_tdata;
        in_keep_q <= s_axis_tkeep;
        in_last_q <= s_axis_tlast;
        in_user_q <= s_axis_tuser;
    end

    assign used  = wr_ptr_q - rd_ptr_q;
    assign free  = PW'(FIFO_DEPTH) - used;
    assign full  = (used == PW'(FIFO_DEPTH));
    assign admit = (free >= PW'(DROP_THRESHOLD));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        inc_rx       = 1'b0;
        inc_drop     = 1'b0;
        inc_ovf      = 1'b0;
        inc_bad      = 1'b0;
        unique case (state_q)
            StSync: begin
                if (armed_q && (!in_valid_q || in_last_q)) state_d = StIdle;
            end
            StIdle, StStore: begin
                if (in_valid_q) begin
                    if (state_q == StIdle && !admit) begin
                        inc_drop = 1'b1;
                        state_d  = in_last_q ? StIdle : StDiscard;
                    end else if (state_q == StStore && full) begin
                        wr_ptr_d = commit_ptr_q;
                        inc_ovf  = 1'b1;
                        state_d  = in_last_q ? StIdle : StDiscard;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        state_d  = StStore;
                        if (in_last_q) begin
                            state_d = StIdle;
                            if (in_user_q) begin
                                wr_ptr_d = commit_ptr_q;
                                inc_bad  = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + PW'(1);
                                inc_rx       = 1'b1;
                            end
                        end
                    end
                end
            end
            StDiscard: begin
                if (in_valid_q && in_last_q) state_d = StIdle;
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q      <= StSync;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
        end
    end

    always_ff @(posedge user_clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= {in_last_q, in_keep_q, in_data_q};
    end

    // The output register mirrors the word at rd_ptr, which is only freed on handshake.
    assign handshake = m_valid_q & m_axis_tready;
    assign fetch_ptr = rd_ptr_q + PW'(m_valid_q);
    assign load      = (!m_valid_q || m_axis_tready) && (fetch_ptr != commit_ptr_q);

    always_ff @(posedge user_clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_word_q  <= '0;
        end else begin
            if (handshake) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (load) begin
                m_word_q  <= mem_q[fetch_ptr[AW-1:0]];
                m_valid_q <= 1'b1;
            end else if (handshake) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic en);
        return (en && (c != '1)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    always_ff @(posedge user_clk) begin
        if (reset) begin
            rx_q   <= '0;
            drop_q <= '0;
            ovf_q  <= '0;
            bad_q  <= '0;
        end else begin
            rx_q   <= sat_inc(rx_q, inc_rx);
            drop_q <= sat_inc(drop_q, inc_drop);
            ovf_q  <= sat_inc(ovf_q, inc_ovf);
            bad_q  <= sat_inc(bad_q, inc_bad);
        end
    end

    assign m_axis_tvalid  = m_valid_q;
    assign m_axis_tlast   = m_word_q[WW-1];
    assign m_axis_tkeep   = m_word_q[DATA_WIDTH +: KW];
    assign m_axis_tdata   = m_word_q[DATA_WIDTH-1:0];
    assign fifo_level     = used;
    assign rx_pkt_count   = rx_q;
    assign drop_pkt_count = drop_q;
    assign overflow_count = ovf_q;
    assign bad_pkt_count  = bad_q;

endmodule

// File: tb/tb_rx_pkt_isolator.sv
// Bench for rx_pkt_isolator: a large and a small instance share one input stream and are
// each compared every cycle against a queue-based frame model.
module tb_rx_pkt_isolator;

    localparam int DW       = 64;
    localparam int KW       = DW / 8;
    localparam int PH_SYNC  = 0;
    localparam int PH_GAP   = 1;
    localparam int PH_FRAME = 2;
    localparam int PH_SKIP  = 3;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic          in_valid, in_last, in_user;
    logic [1:0]    rdy;
    logic [DW-1:0] o_data [2];
    logic [KW-1:0] o_keep [2];
    logic          o_valid [2];
    logic          o_last [2];
    logic [11:0]   lvl0;
    logic [4:0]    lvl1;
    logic [31:0]   rxc [2];
    logic [31:0]   dropc [2];
    logic [31:0]   ovfc [2];
    logic [31:0]   badc [2];

    rx_pkt_isolator #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(2048), .DROP_THRESHOLD(256), .CNT_WIDTH(32)
    ) u_dut_big (
        .user_clk(clk), .reset(rst),
        .s_axis_tdata(in_data), .s_axis_tkeep(in_keep), .s_axis_tvalid(in_valid),
        .s_axis_tlast(in_last), .s_axis_tuser(in_user),
        .m_axis_tdata(o_data[0]), .m_axis_tkeep(o_keep[0]), .m_axis_tvalid(o_valid[0]),
        .m_axis_tlast(o_last[0]), .m_axis_tready(rdy[0]),
        .fifo_level(lvl0), .rx_pkt_count(rxc[0]), .drop_pkt_count(dropc[0]),
        .overflow_count(ovfc[0]), .bad_pkt_count(badc[0])
    );

    rx_pkt_isolator #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(16), .DROP_THRESHOLD(8), .CNT_WIDTH(32)
    ) u_dut_small (
        .user_clk(clk), .reset(rst),
        .s_axis_tdata(in_data), .s_axis_tkeep(in_keep), .s_axis_tvalid(in_valid),
        .s_axis_tlast(in_last), .s_axis_tuser(in_user),
        .m_axis_tdata(o_data[1]), .m_axis_tkeep(o_keep[1]), .m_axis_tvalid(o_valid[1]),
        .m_axis_tlast(o_last[1]), .m_axis_tready(rdy[1]),
        .fifo_level(lvl1), .rx_pkt_count(rxc[1]), .drop_pkt_count(dropc[1]),
        .overflow_count(ovfc[1]), .bad_pkt_count(badc[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: fifo_q holds committed words followed by pend_n words of the frame in progress.
    int    depth_c [2] = '{2048, 16};
    int    thr_c [2]   = '{256, 8};
    beat_t fifo_q [2][$];
    int    pend_n [2], phase [2];
    bit    armed [2], rb_v [2], rb_user [2], ov [2];
    beat_t rb [2], ob [2];
    int    m_rx [2], m_drop [2], m_ovf [2], m_bad [2], m_commit [2];
    int    cyc = 0;
    int    hs_cnt [2] = '{0, 0};
    int    rise_cyc [2] = '{0, 0};
    bit    prev_v [2] = '{1'b0, 1'b0};

    function automatic void drop_pending(input int i);
        repeat (pend_n[i]) void'(fifo_q[i].pop_back());
        pend_n[i] = 0;
    endfunction

    function automatic void frame_end(input int i);
        if (rb_user[i]) begin
            drop_pending(i);
            m_bad[i]++;
        end else begin
            m_commit[i] += pend_n[i];
            pend_n[i] = 0;
            m_rx[i]++;
        end
    endfunction

    function automatic void model_step(input int i);
        int  held;
        bit  ld;
        if (rst) begin
            fifo_q[i].delete();
            pend_n[i] = 0; phase[i] = PH_SYNC; armed[i] = 0; rb_v[i] = 0; ov[i] = 0; ob[i] = '0;
            m_rx[i] = 0; m_drop[i] = 0; m_ovf[i] = 0; m_bad[i] = 0; m_commit[i] = 0;
            return;
        end
        held = fifo_q[i].size() + int'(ov[i]);
        ld   = (!ov[i] || rdy[i]) && (fifo_q[i].size() > pend_n[i]);
        if (ov[i] && rdy[i]) ov[i] = 0;
        if (ld) begin
            ob[i] = fifo_q[i].pop_front();
            ov[i] = 1;
        end
        case (phase[i])
            PH_SYNC: if (armed[i] && (!rb_v[i] || rb[i].last)) phase[i] = PH_GAP;
            PH_GAP: if (rb_v[i]) begin
                if (depth_c[i] - held >= thr_c[i]) begin
                    fifo_q[i].push_back(rb[i]);
                    pend_n[i]++;
                    if (rb[i].last) frame_end(i);
                    else phase[i] = PH_FRAME;
                end else begin
                    m_drop[i]++;
                    if (!rb[i].last) phase[i] = PH_SKIP;
                end
            end
            PH_FRAME: if (rb_v[i]) begin
                if (held == depth_c[i]) begin
                    drop_pending(i);
                    m_ovf[i]++;
                    phase[i] = rb[i].last ? PH_GAP : PH_SKIP;
                end else begin
                    fifo_q[i].push_back(rb[i]);
                    pend_n[i]++;
                    if (rb[i].last) begin
                        frame_end(i);
                        phase[i] = PH_GAP;
                    end
                end
            end
            default: if (rb_v[i] && rb[i].last) phase[i] = PH_GAP;
        endcase
        armed[i]   = 1;
        rb_v[i]    = in_valid;
        rb[i]      = {in_last, in_keep, in_data};
        rb_user[i] = in_user;
    endfunction

    task automatic observe();
        logic [11:0] lv;
        for (int i = 0; i < 2; i++) begin
            lv = (i == 0) ? lvl0 : {7'b0, lvl1};
            check($sformatf("valid%0d@%0d", i, cyc), 128'(o_valid[i]), 128'(ov[i]));
            if (ov[i])
                check($sformatf("beat%0d@%0d", i, cyc), 128'({o_last[i], o_keep[i], o_data[i]}),
                      128'(ob[i]));
            check($sformatf("level%0d@%0d", i, cyc), 128'(lv),
                  128'(fifo_q[i].size() + int'(ov[i])));
            check($sformatf("counters%0d@%0d", i, cyc),
                  {rxc[i], dropc[i], ovfc[i], badc[i]},
                  {32'(m_rx[i]), 32'(m_drop[i]), 32'(m_ovf[i]), 32'(m_bad[i])});
            if (o_valid[i] && rdy[i]) hs_cnt[i]++;
            if (o_valid[i] && !prev_v[i]) rise_cyc[i] = cyc;
            prev_v[i] = o_valid[i];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input bit rand_rdy);
        repeat (n) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (rand_rdy) rdy = 2'($urandom);
            tick();
        end
    endtask

    task automatic send_frame(input int len, input bit bad, input bit rand_rdy,
                              output int t_last);
        t_last = 0;
        for (int b = 0; b < len; b++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_keep  = 8'($urandom);
            in_last  = (b == len - 1);
            in_user  = in_last ? bad : 1'($urandom);
            if (rand_rdy) rdy = 2'($urandom);
            if (in_last) t_last = cyc;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2, 1'b0);
        rst = 1'b0;
        idle(2, 1'b0);
    endtask

    initial begin
        int t0, t1, t2;
        int base [2];
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
        in_data = '0; in_keep = '0; rdy = 2'b11;
        model_step(0);
        model_step(1);

        // Clean back-to-back frames.
        do_reset();
        base[0] = hs_cnt[0];
        send_frame(8, 1'b0, 1'b0, t0);
        send_frame(8, 1'b0, 1'b0, t1);
        send_frame(8, 1'b0, 1'b0, t2);
        idle(30, 1'b0);
        check("clean_rx_count", 128'(rxc[0]), 128'(3));
        check("clean_beats", 128'(hs_cnt[0] - base[0]), 128'(24));
        check("clean_latency", 128'(rise_cyc[0] - t0), 128'(3));

        // Bad frame between two good ones.
        do_reset();
        base[0] = hs_cnt[0];
        send_frame(5, 1'b0, 1'b0, t0);
        send_frame(4, 1'b1, 1'b0, t0);
        send_frame(6, 1'b0, 1'b0, t0);
        idle(30, 1'b0);
        check("bad_count", 128'(badc[0]), 128'(1));
        check("bad_rx_count", 128'(rxc[0]), 128'(2));
        check("bad_beats", 128'(hs_cnt[0] - base[0]), 128'(11));
        check("bad_level", 128'(lvl0), 128'(0));

        // Threshold drop on the small instance.
        do_reset();
        rdy = 2'b00;
        send_frame(10, 1'b0, 1'b0, t0);
        send_frame(5, 1'b0, 1'b0, t0);
        idle(5, 1'b0);
        check("thr_drop_count", 128'(dropc[1]), 128'(1));
        check("thr_level", 128'(lvl1), 128'(10));
        rdy = 2'b11;
        idle(30, 1'b0);

        // Mid-frame overflow on the small instance.
        do_reset();
        rdy = 2'b00;
        send_frame(20, 1'b0, 1'b0, t0);
        idle(5, 1'b0);
        check("ovf_count", 128'(ovfc[1]), 128'(1));
        check("ovf_level", 128'(lvl1), 128'(0));
        base[1] = hs_cnt[1];
        rdy = 2'b11;
        idle(20, 1'b0);
        check("ovf_no_output", 128'(hs_cnt[1] - base[1]), 128'(0));

        // Random frames, random backpressure, pointer wrap.
        do_reset();
        base[0] = hs_cnt[0];
        base[1] = hs_cnt[1];
        for (int f = 0; f < 200; f++) begin
            idle($urandom_range(0, 3), 1'b1);
            send_frame($urandom_range(1, 20), ($urandom_range(0, 7) == 0), 1'b1, t0);
        end
        rdy = 2'b11;
        idle(1200, 1'b0);
        check("rand_beats_big", 128'(hs_cnt[0] - base[0]), 128'(m_commit[0]));
        check("rand_beats_small", 128'(hs_cnt[1] - base[1]), 128'(m_commit[1]));
        check("rand_level_small", 128'(lvl1), 128'(0));

        // Reset in the middle of a frame; the tail must be swallowed.
        do_reset();
        base[0] = hs_cnt[0];
        for (int b = 0; b < 6; b++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_keep  = 8'($urandom);
            in_last  = (b == 5);
            in_user  = 1'b0;
            rst      = (b == 2);
            tick();
        end
        rst = 1'b0;
        idle(3, 1'b0);
        send_frame(4, 1'b0, 1'b0, t0);
        idle(20, 1'b0);
        check("rst_rx_count", 128'(rxc[0]), 128'(1));
        check("rst_rx_count_small", 128'(rxc[1]), 128'(1));
        check("rst_beats", 128'(hs_cnt[0] - base[0]), 128'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
